// File: rtl/data_sram_responder.sv
// Data SRAM responder: word RAM plus confreg MMIO window (LED, switch, NUM, timer).
// Define DATA_SRAM_TIMER_EN to build the TIMER/TCMP/TCTRL registers and timer_int.
module data_sram_responder #(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] CONF_HI = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_int
);

    localparam logic [15:0] OFF_LED   = 16'hf000;
    localparam logic [15:0] OFF_SW    = 16'hf004;
    localparam logic [15:0] OFF_NUM   = 16'hf010;
    localparam logic [15:0] OFF_TIMER = 16'he000;
    localparam logic [15:0] OFF_TCMP  = 16'he004;
    localparam logic [15:0] OFF_TCTRL = 16'he008;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    logic              conf_sel, wr, rd, wr_conf, wr_ram;
    logic [15:0]       off;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr;

    assign conf_sel    = (data_sram_addr[31:16] == CONF_HI);
    assign off         = data_sram_addr[15:0];
    assign ram_idx     = data_sram_addr[RAM_AW+1:2];
    assign wr          = data_sram_en & (|data_sram_wen);
    assign rd          = data_sram_en & ~(|data_sram_wen);
    assign wr_conf     = wr & conf_sel;
    assign wr_ram      = wr & ~conf_sel;
    assign unused_addr = ^data_sram_addr[1:0];

    // RAM contents are deliberately not reset.
    logic [31:0] mem_q [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            for (int i = 0; i < 4; i++)
                if (data_sram_wen[i]) mem_q[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
    end

    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] led_m, conf_rd, rd_word;

    assign led_m = merge({16'b0, led_q}, data_sram_wdata, data_sram_wen);

`ifdef DATA_SRAM_TIMER_EN
    logic [31:0] timer_q, timer_d, tcmp_q, tcmp_d;
    logic        ien_q, ien_d, pend_q, pend_d;

    always_comb begin
        timer_d = timer_q + 32'd1;
        tcmp_d  = tcmp_q;
        ien_d   = ien_q;
        pend_d  = pend_q;
        if (wr_conf && off == OFF_TIMER) timer_d = merge(timer_q, data_sram_wdata, data_sram_wen);
        if (wr_conf && off == OFF_TCMP)  tcmp_d  = merge(tcmp_q, data_sram_wdata, data_sram_wen);
        if (wr_conf && off == OFF_TCTRL && data_sram_wen[0]) begin
            ien_d = data_sram_wdata[0];
            if (data_sram_wdata[1]) pend_d = 1'b0;
        end
        // A compare match outranks a simultaneous write-1-clear.
        if (timer_q == tcmp_q) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= 32'd0;
            tcmp_q  <= 32'hffff_ffff;
            ien_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            tcmp_q  <= tcmp_d;
            ien_q   <= ien_d;
            pend_q  <= pend_d;
        end
    end

    assign timer_int = ien_q & pend_q;
`else
    assign timer_int = 1'b0;
`endif

    always_comb begin
        conf_rd = 32'd0;
        case (off)
            OFF_LED:   conf_rd = {16'b0, led_q};
            OFF_SW:    conf_rd = {24'b0, switch};
            OFF_NUM:   conf_rd = num_q;
`ifdef DATA_SRAM_TIMER_EN
            OFF_TIMER: conf_rd = timer_q;
            OFF_TCMP:  conf_rd = tcmp_q;
            OFF_TCTRL: conf_rd = {30'b0, pend_q, ien_q};
`endif
            default:   conf_rd = 32'd0;
        endcase
    end

    assign rd_word = conf_sel ? conf_rd : mem_q[ram_idx];

    always_comb begin
        led_d   = led_q;
        num_d   = num_q;
        rdata_d = rdata_q;
        if (wr_conf && off == OFF_LED) led_d = led_m[15:0];
        if (wr_conf && off == OFF_NUM) num_d = merge(num_q, data_sram_wdata, data_sram_wen);
        if (rd) rdata_d = rd_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q   <= 16'd0;
            num_q   <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            led_q   <= led_d;
            num_q   <= num_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule
